// File: rtl/ctrl_pkg.sv
// Shared decode/control definitions for the ID/EX boundary: ALU op encodings and the
// packed control bundle carried down the pipe.
package ctrl_pkg;

    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_LUI  = 4'd11;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic                reg_dst;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    // Bubble and reset both load this, so an empty slot can never write anything.
    localparam ctrl_t ZERO_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds a source of the
// instruction currently in decode.
module load_use_detect #(
    parameter int unsigned RA_W = 5
) (
    input  logic            ex_valid_i,
    input  logic            ex_mem_read_i,
    input  logic [RA_W-1:0] ex_rt_i,
    input  logic            id_valid_i,
    input  logic [RA_W-1:0] id_rs_i,
    input  logic [RA_W-1:0] id_rt_i,
    input  logic            id_uses_rt_i,
    output logic            hazard_o
);

    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    // r0 is hardwired to zero, so a load targeting it never produces a real dependency.
    assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0);
    assign rs_match   = (ex_rt_i == id_rs_i);
    assign rt_match   = id_uses_rt_i & (ex_rt_i == id_rt_i);
    assign hazard_o   = id_valid_i & ex_is_load & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use interlock, branch squash and a saturating
// stall-cycle counter.
module id_ex_register
    import ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ID_valid,
    input  logic [RA_W-1:0]   ID_rs,
    input  logic [RA_W-1:0]   ID_rt,
    input  logic [RA_W-1:0]   ID_rd,
    input  logic              ID_uses_rt,
    input  logic [DATA_W-1:0] ID_rs_data,
    input  logic [DATA_W-1:0] ID_rt_data,
    input  logic [DATA_W-1:0] ID_imm,
    input  logic              ID_reg_write,
    input  logic              ID_mem_read,
    input  logic              ID_mem_write,
    input  logic              ID_mem_to_reg,
    input  logic              ID_alu_src,
    input  logic              ID_reg_dst,
    input  logic [3:0]        ID_alu_op,
    input  logic              EX_flush,

    output logic              ID_EX_valid,
    output logic [RA_W-1:0]   ID_EX_rs,
    output logic [RA_W-1:0]   ID_EX_rt,
    output logic [RA_W-1:0]   ID_EX_rd,
    output logic [DATA_W-1:0] ID_EX_rs_data,
    output logic [DATA_W-1:0] ID_EX_rt_data,
    output logic [DATA_W-1:0] ID_EX_imm,
    output logic              ID_EX_reg_write,
    output logic              ID_EX_mem_read,
    output logic              ID_EX_mem_write,
    output logic              ID_EX_mem_to_reg,
    output logic              ID_EX_alu_src,
    output logic              ID_EX_reg_dst,
    output logic [3:0]        ID_EX_alu_op,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              valid_q,   valid_d;
    logic [RA_W-1:0]   rs_q,      rs_d;
    logic [RA_W-1:0]   rt_q,      rt_d;
    logic [RA_W-1:0]   rd_q,      rd_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    ctrl_t             ctrl_q,    ctrl_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    ctrl_t id_ctrl;
    logic  hazard;

    assign id_ctrl = '{
        reg_write:  ID_reg_write,
        mem_read:   ID_mem_read,
        mem_write:  ID_mem_write,
        mem_to_reg: ID_mem_to_reg,
        alu_src:    ID_alu_src,
        reg_dst:    ID_reg_dst,
        alu_op:     ID_alu_op
    };

    load_use_detect #(
        .RA_W (RA_W)
    ) u_load_use_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rt_i       (rt_q),
        .id_valid_i    (ID_valid),
        .id_rs_i       (ID_rs),
        .id_rt_i       (ID_rt),
        .id_uses_rt_i  (ID_uses_rt),
        .hazard_o      (hazard)
    );

    // A taken branch discards decode anyway, so holding the front end would be pointless.
    assign stall = hazard & ~EX_flush;

    always_comb begin
        valid_d   = 1'b0;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        ctrl_d    = ZERO_CTRL;
        if (!EX_flush && !hazard) begin
            valid_d   = ID_valid;
            rs_d      = ID_rs;
            rt_d      = ID_rt;
            rd_d      = ID_rd;
            rs_data_d = ID_rs_data;
            rt_data_d = ID_rt_data;
            imm_d     = ID_imm;
            ctrl_d    = ID_valid ? id_ctrl : ZERO_CTRL;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= ZERO_CTRL;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ID_EX_valid      = valid_q;
    assign ID_EX_rs         = rs_q;
    assign ID_EX_rt         = rt_q;
    assign ID_EX_rd         = rd_q;
    assign ID_EX_rs_data    = rs_data_q;
    assign ID_EX_rt_data    = rt_data_q;
    assign ID_EX_imm        = imm_q;
    assign ID_EX_reg_write  = ctrl_q.reg_write;
    assign ID_EX_mem_read   = ctrl_q.mem_read;
    assign ID_EX_mem_write  = ctrl_q.mem_write;
    assign ID_EX_mem_to_reg = ctrl_q.mem_to_reg;
    assign ID_EX_alu_src    = ctrl_q.alu_src;
    assign ID_EX_reg_dst    = ctrl_q.reg_dst;
    assign ID_EX_alu_op     = ctrl_q.alu_op;
    assign stall_count      = cnt_q;

endmodule
